// File: rtl/op_dec_master.sv
// op_dec_master: initiator end of the 2-to-4 operation-decoder interface.
//
// Arbitrates among four requesters, drives the winning index onto DEC with
// ENABLE and latched operands A/B, waits SETTLE cycles, captures the selected
// decoder result and hands it out through a RESULT/RES_VALID/RES_READY
// handshake.
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   REQ[3:0]   request vector, bit i requests operation i
//   IN_A/IN_B  operands, sampled on grant
//   GNT[3:0]   one-hot grant, single-cycle pulse in the first ISSUE cycle
//   A/B        latched operands to the decoder
//   DEC[1:0]   encoded operation select
//   ENABLE     decoder enable
//   OP0..OP3   decoder results
//   RESULT     captured result
//   RES_IDX    index of the captured operation
//   RES_VALID  result valid
//   RES_READY  result consumer ready
//
// Build option:
//   ROUND_ROBIN_EN  defined: round-robin arbitration with a rotating pointer.
//                   undefined: fixed priority, lowest set REQ bit wins.

module op_dec_master #(
    parameter int unsigned W_OPD  = 4,
    parameter int unsigned W_RES  = 8,
    parameter int unsigned SETTLE = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       REQ,
    input  logic [W_OPD-1:0] IN_A,
    input  logic [W_OPD-1:0] IN_B,
    output logic [3:0]       GNT,
    output logic [W_OPD-1:0] A,
    output logic [W_OPD-1:0] B,
    output logic [1:0]       DEC,
    output logic             ENABLE,
    input  logic [W_RES-1:0] OP0,
    input  logic [W_RES-1:0] OP1,
    input  logic [W_RES-1:0] OP2,
    input  logic [W_RES-1:0] OP3,
    output logic [W_RES-1:0] RESULT,
    output logic [1:0]       RES_IDX,
    output logic             RES_VALID,
    input  logic             RES_READY
);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_e           state;
    logic [3:0]       cnt;
    logic [1:0]       idx_sel;
    logic [W_RES-1:0] op_sel;

`ifdef ROUND_ROBIN_EN
    logic [1:0] ptr;
    logic [1:0] cand;

    // Scan from the farthest offset down so the first set bit at or after
    // ptr (wrapping 3->0) is the last assignment and wins.
    always_comb begin
        idx_sel = '0;
        cand    = '0;
        for (int off = 3; off >= 0; off--) begin
            cand = ptr + 2'(off);
            if (REQ[cand]) begin
                idx_sel = cand;
            end
        end
    end
`else
    // Scan high to low so the lowest set bit is the last assignment and wins.
    always_comb begin
        idx_sel = '0;
        for (int i = 3; i >= 0; i--) begin
            if (REQ[i]) begin
                idx_sel = 2'(i);
            end
        end
    end
`endif

    // DEC is stable throughout ISSUE, so it selects the result to capture.
    always_comb begin
        op_sel = OP0;
        unique case (DEC)
            2'd0: op_sel = OP0;
            2'd1: op_sel = OP1;
            2'd2: op_sel = OP2;
            2'd3: op_sel = OP3;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= StIdle;
            cnt       <= '0;
            GNT       <= '0;
            A         <= '0;
            B         <= '0;
            DEC       <= '0;
            ENABLE    <= 1'b0;
            RESULT    <= '0;
            RES_IDX   <= '0;
            RES_VALID <= 1'b0;
`ifdef ROUND_ROBIN_EN
            ptr       <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    GNT    <= '0;
                    ENABLE <= 1'b0;
                    if (|REQ) begin
                        A       <= IN_A;
                        B       <= IN_B;
                        DEC     <= idx_sel;
                        RES_IDX <= idx_sel;
                        GNT     <= 4'b0001 << idx_sel;
                        ENABLE  <= 1'b1;
                        cnt     <= CNT_INIT;
                        state   <= StIssue;
`ifdef ROUND_ROBIN_EN
                        ptr     <= idx_sel + 2'd1;
`endif
                    end
                end
                StIssue: begin
                    GNT <= '0;
                    if (cnt == 4'd0) begin
                        RESULT    <= op_sel;
                        ENABLE    <= 1'b0;
                        RES_VALID <= 1'b1;
                        state     <= StDone;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StDone: begin
                    if (RES_READY) begin
                        RES_VALID <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_op_dec_master.sv
// Directed bench for op_dec_master: two instances, SETTLE=1 (u1) and
// SETTLE=4 (u4), sharing operands and decoder results.

module tb_op_dec_master;

    logic       clk;
    logic [3:0] in_a, in_b;
    logic [7:0] op0, op1, op2, op3;

    logic       rst1, ready1;
    logic [3:0] req1, gnt1, a1, b1;
    logic [1:0] dec1, idx1;
    logic       en1, valid1;
    logic [7:0] res1;

    logic       rst4, ready4;
    logic [3:0] req4, gnt4, a4, b4;
    logic [1:0] dec4, idx4;
    logic       en4, valid4;
    logic [7:0] res4;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_idx [5];
    logic [3:0] seq_req;

    op_dec_master #(.W_OPD(4), .W_RES(8), .SETTLE(1)) u1 (
        .CLK(clk), .RST(rst1), .REQ(req1), .IN_A(in_a), .IN_B(in_b),
        .GNT(gnt1), .A(a1), .B(b1), .DEC(dec1), .ENABLE(en1),
        .OP0(op0), .OP1(op1), .OP2(op2), .OP3(op3),
        .RESULT(res1), .RES_IDX(idx1), .RES_VALID(valid1), .RES_READY(ready1)
    );

    op_dec_master #(.W_OPD(4), .W_RES(8), .SETTLE(4)) u4 (
        .CLK(clk), .RST(rst4), .REQ(req4), .IN_A(in_a), .IN_B(in_b),
        .GNT(gnt4), .A(a4), .B(b4), .DEC(dec4), .ENABLE(en4),
        .OP0(op0), .OP1(op1), .OP2(op2), .OP3(op3),
        .RESULT(res4), .RES_IDX(idx4), .RES_VALID(valid4), .RES_READY(ready4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] op_of(input logic [1:0] i);
        return 8'((32'(i) + 1) * 17);
    endfunction

    initial begin
        in_a = 4'h3; in_b = 4'h4;
        op0 = 8'h11; op1 = 8'h22; op2 = 8'h33; op3 = 8'h44;
        rst1 = 1'b1; req1 = 4'hF; ready1 = 1'b1;
        rst4 = 1'b1; req4 = 4'h0; ready4 = 1'b1;

        // Reset held two cycles with all requests up.
        step();
        chk("rst_gnt_c1", 32'(gnt1), 32'h0);
        step();
        chk("rst_gnt", 32'(gnt1), 32'h0);
        chk("rst_a", 32'(a1), 32'h0);
        chk("rst_b", 32'(b1), 32'h0);
        chk("rst_dec", 32'(dec1), 32'h0);
        chk("rst_en", 32'(en1), 32'h0);
        chk("rst_res", 32'(res1), 32'h0);
        chk("rst_idx", 32'(idx1), 32'h0);
        chk("rst_valid", 32'(valid1), 32'h0);

        rst1 = 1'b0;
        step();
        chk("first_gnt", 32'(gnt1), 32'h1);
        chk("first_en", 32'(en1), 32'h1);
        step();
        chk("first_valid", 32'(valid1), 32'h1);
        chk("first_res", 32'(res1), 32'h11);
        req1 = 4'h0;
        step();
        chk("first_done_valid", 32'(valid1), 32'h0);
        step();
        chk("idle_en", 32'(en1), 32'h0);

        // Single request on op 2.
        req1 = 4'b0100;
        step();
        chk("single_dec", 32'(dec1), 32'h2);
        chk("single_a", 32'(a1), 32'h3);
        chk("single_b", 32'(b1), 32'h4);
        chk("single_en", 32'(en1), 32'h1);
        chk("single_gnt", 32'(gnt1), 32'b0100);
        req1 = 4'hF;
        ready1 = 1'b0;
        step();
        chk("single_valid", 32'(valid1), 32'h1);
        chk("single_res", 32'(res1), 32'h33);
        chk("single_idx", 32'(idx1), 32'h2);

        // Backpressure: result held, no new grant.
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_res", 32'(res1), 32'h33);
            chk("bp_en", 32'(en1), 32'h0);
            chk("bp_gnt", 32'(gnt1), 32'h0);
            chk("bp_valid", 32'(valid1), 32'h1);
        end
        req1 = 4'h0;
        ready1 = 1'b1;
        step();
        chk("bp_release_valid", 32'(valid1), 32'h0);
        chk("bp_release_gnt", 32'(gnt1), 32'h0);

        // Restart pointer from 0 for the arbitration sequence.
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
`ifdef ROUND_ROBIN_EN
        seq_req = 4'b1111;
        exp_idx[0] = 2'd0; exp_idx[1] = 2'd1; exp_idx[2] = 2'd2;
        exp_idx[3] = 2'd3; exp_idx[4] = 2'd0;
`else
        seq_req = 4'b1010;
        exp_idx[0] = 2'd1; exp_idx[1] = 2'd1; exp_idx[2] = 2'd1;
        exp_idx[3] = 2'd1; exp_idx[4] = 2'd1;
`endif
        req1 = seq_req;
        for (int t = 0; t < 5; t++) begin
            step();
            chk("arb_dec", 32'(dec1), 32'(exp_idx[t]));
            chk("arb_gnt", 32'(gnt1), 32'(4'b0001 << exp_idx[t]));
            step();
            chk("arb_valid", 32'(valid1), 32'h1);
            chk("arb_idx", 32'(idx1), 32'(exp_idx[t]));
            chk("arb_res", 32'(res1), 32'(op_of(exp_idx[t])));
            step();
            chk("arb_idle_valid", 32'(valid1), 32'h0);
        end
        req1 = 4'h0;

        // Mid-transaction reset on the SETTLE=4 instance.
        rst4 = 1'b0;
        req4 = 4'b0100;
        step();
        chk("mid_gnt", 32'(gnt4), 32'b0100);
        chk("mid_en1", 32'(en4), 32'h1);
        req4 = 4'h0;
        step();
        chk("mid_en2", 32'(en4), 32'h1);
        rst4 = 1'b1;
        step();
        chk("mid_rst_en", 32'(en4), 32'h0);
        chk("mid_rst_valid", 32'(valid4), 32'h0);
        rst4 = 1'b0;
        step();
        chk("mid_idle_valid", 32'(valid4), 32'h0);
        chk("mid_idle_en", 32'(en4), 32'h0);
        req4 = 4'hF;
        step();
        chk("mid_restart_gnt", 32'(gnt4), 32'h1);
        chk("mid_restart_dec", 32'(dec4), 32'h0);
        req4 = 4'h0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("mid_issue_en", 32'(en4), 32'h1);
            chk("mid_issue_valid", 32'(valid4), 32'h0);
        end
        step();
        chk("mid_done_valid", 32'(valid4), 32'h1);
        chk("mid_done_res", 32'(res4), 32'h11);
        chk("mid_done_en", 32'(en4), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/op_dec_master.md
Name: op_dec_master

Overview:
- Encoder/initiator end of the 2-to-4 operation-decoder interface.
- Arbitrates among four operation requesters and encodes the winner into the 2-bit select DEC, with ENABLE and latched 4-bit operands A/B.
- Waits a settle interval, captures the matching 8-bit op result, and returns it through a valid/ready handshake.
- Sits between requesting logic and the combinational operation decoder.

Parameters:
- W_OPD, 4, operand width of A/B.
- W_RES, 8, result width of each op input.
- SETTLE, 1, cycles ENABLE is held before capture; legal range 1..15.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  4  request vector; bit i requests operation i.
- IN_A  in  W_OPD  operand A, sampled on grant.
- IN_B  in  W_OPD  operand B, sampled on grant.
- GNT  out  4  one-hot grant, single-cycle pulse.
- A  out  W_OPD  latched operand A to decoder.
- B  out  W_OPD  latched operand B to decoder.
- DEC  out  2  encoded operation select.
- ENABLE  out  1  decoder enable.
- OP0, OP1, OP2, OP3  in  W_RES each  decoder results.
- RESULT  out  W_RES  captured result.
- RES_IDX  out  2  index of captured operation.
- RES_VALID  out  1  result valid.
- RES_READY  in  1  result consumer ready.

Behaviour:
- Reset (RST high at an edge):
  - state = IDLE; all outputs 0 (GNT, A, B, DEC, ENABLE, RESULT, RES_IDX, RES_VALID); settle counter 0; round-robin pointer 0.
  - Reset mid-transaction abandons it: ENABLE and RES_VALID are low from the cycle after the reset edge; no result is produced.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - ENABLE=0.
  - If REQ != 0 at edge k: select index idx (arbitration below), latch IN_A/IN_B into A/B, DEC=idx, RES_IDX=idx, load counter = SETTLE-1, go to ISSUE.
  - REQ == 0: remain in IDLE.
- ISSUE (cycles k+1 .. k+SETTLE):
  - ENABLE=1; DEC/A/B stable.
  - GNT[idx]=1 in cycle k+1 only.
  - Counter decrements each cycle. At the edge where counter == 0, capture OP[idx] into RESULT and go to DONE.
  - REQ changes during ISSUE are ignored.
- DONE:
  - ENABLE=0, RES_VALID=1; RESULT and RES_IDX are held stable while RES_VALID=1 and RES_READY=0.
  - At an edge with RES_READY=1: RES_VALID→0, go to IDLE.
- DEC/A/B keep their last values after ENABLE drops; the decoder ignores them while ENABLE=0.
- Timing:
  - Latency from REQ sampled to RES_VALID high: SETTLE+1 cycles.
  - Minimum transaction period with RES_READY tied high: SETTLE+2 cycles.
- Arbitration (default, fixed priority): lowest set REQ bit wins. REQ=4'b1010 → idx=1.
- Width rules: no arithmetic on operands; RESULT is a straight copy of the selected W_RES input.

Optional Feature:
- Macro ROUND_ROBIN_EN.
- Defined:
  - Search starts at pointer p and wraps 3→0; first set bit wins.
  - On grant, p = idx+1 mod 4; pointer 3+1 wraps to 0.
  - Reset sets p=0.
- Undefined: fixed priority as above; no pointer register.

Test Plan:
- Reset values: RST high 2 cycles, REQ=4'hF → every output 0, no GNT pulse; after release, first grant GNT=4'b0001.
- Single request: SETTLE=1, OP0..OP3 = 8'h11/8'h22/8'h33/8'h44, REQ=4'b0100, IN_A=4'h3, IN_B=4'h4.
  - → cycle k+1: DEC=2, A=3, B=4, ENABLE=1, GNT=4'b0100.
  - → cycle k+2: RES_VALID=1, RESULT=8'h33, RES_IDX=2.
- Backpressure: hold RES_READY=0 for 5 cycles in DONE → RESULT stays 8'h33, ENABLE=0, no new GNT despite REQ=4'hF; release → IDLE next cycle.
- Fixed priority: REQ=4'b1010 held through three transactions → idx sequence 1,1,1.
- ROUND_ROBIN_EN defined: REQ=4'b1111 held → idx sequence 0,1,2,3,0 (wrap-around).
- Mid-transaction reset: SETTLE=4, assert RST during the 2nd ISSUE cycle → ENABLE=0 next cycle, RES_VALID never asserts, next transaction restarts from idx=0.
